// File: rtl/ysyx_23060208_pkg.sv
// Shared types for the ysyx_23060208 load/store unit: FSM states, response
// codes, access sizes and the alignment rule used at request acceptance.
package ysyx_23060208_pkg;

  typedef enum logic [2:0] {
    IDLE,
    RD_AR,
    RD_R,
    WR_AWW,
    WR_B,
    RESP,
    DRAIN
  } lsu_state_e;

  typedef enum logic [1:0] {
    ERR_OK       = 2'd0,
    ERR_MISALIGN = 2'd1,
    ERR_BUS      = 2'd2,
    ERR_TIMEOUT  = 2'd3
  } lsu_err_e;

  typedef enum logic [1:0] {
    SIZE_B = 2'd0,
    SIZE_H = 2'd1,
    SIZE_W = 2'd2,
    SIZE_D = 2'd3
  } lsu_size_e;

  typedef enum logic [1:0] {
    AXI_OKAY   = 2'b00,
    AXI_EXOKAY = 2'b01,
    AXI_SLVERR = 2'b10,
    AXI_DECERR = 2'b11
  } axi_resp_e;

  // A doubleword is only legal on a 64-bit bus.
  function automatic logic is_misaligned(input logic [1:0] size, input logic [2:0] addr_lo,
                                         input logic bus64);
    case (lsu_size_e'(size))
      SIZE_B:  return 1'b0;
      SIZE_H:  return addr_lo[0];
      SIZE_W:  return |addr_lo[1:0];
      default: return !bus64 || (|addr_lo);
    endcase
  endfunction

endpackage

// File: rtl/ysyx_23060208_lsu_align.sv
// Byte-lane steering: store data/strobe placement and load data extraction
// with sign or zero extension.
module ysyx_23060208_lsu_align
  import ysyx_23060208_pkg::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input  logic [$clog2(DATA_WIDTH/8)-1:0] offset_i,
  input  logic [1:0]                      size_i,
  input  logic                            signed_i,
  input  logic [DATA_WIDTH-1:0]           wdata_i,
  input  logic [DATA_WIDTH-1:0]           rdata_i,
  output logic [DATA_WIDTH-1:0]           wdata_o,
  output logic [DATA_WIDTH/8-1:0]         wstrb_o,
  output logic [DATA_WIDTH-1:0]           rdata_o
);

  localparam int NB = DATA_WIDTH / 8;

  logic [NB-1:0]         base_strb;
  logic [DATA_WIDTH-1:0] shifted;
  logic [DATA_WIDTH-1:0] keep_mask;
  logic                  sign_bit;

  assign wdata_o = wdata_i << {offset_i, 3'b000};
  assign wstrb_o = base_strb << offset_i;
  assign shifted = rdata_i >> {offset_i, 3'b000};

  // NOTE: every output of a combinational block gets a default first so no
  // path through the case can leave it unassigned and infer a latch.
  always_comb begin
    base_strb = '1;
    keep_mask = '1;
    sign_bit  = shifted[DATA_WIDTH-1];
    case (lsu_size_e'(size_i))
      SIZE_B: begin
        base_strb = NB'(1);
        keep_mask = DATA_WIDTH'(8'hFF);
        sign_bit  = shifted[7];
      end
      SIZE_H: begin
        base_strb = NB'(3);
        keep_mask = DATA_WIDTH'(16'hFFFF);
        sign_bit  = shifted[15];
      end
      SIZE_W: begin
        base_strb = NB'(4'hF);
        keep_mask = DATA_WIDTH'(32'hFFFF_FFFF);
        sign_bit  = shifted[31];
      end
      default: ;
    endcase
  end

  assign rdata_o = (shifted & keep_mask) | ((signed_i && sign_bit) ? ~keep_mask : '0);

endmodule

// File: rtl/ysyx_23060208_lsu.sv
// Single-outstanding load/store unit bridging a valid/ready request port to
// an AXI4-Lite master, with misalignment, bus-error and timeout reporting.
module ysyx_23060208_lsu
  import ysyx_23060208_pkg::*;
#(
  parameter int DATA_WIDTH     = 32,
  parameter int ADDR_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    req_valid,
  output logic                    req_ready,
  input  logic                    req_we,
  input  logic [1:0]              req_size,
  input  logic                    req_signed,
  input  logic [ADDR_WIDTH-1:0]   req_addr,
  input  logic [DATA_WIDTH-1:0]   req_wdata,
  output logic                    resp_valid,
  input  logic                    resp_ready,
  output logic [DATA_WIDTH-1:0]   resp_rdata,
  output logic [1:0]              resp_err,
  output logic [ADDR_WIDTH-1:0]   awaddr,
  output logic                    awvalid,
  input  logic                    awready,
  output logic [DATA_WIDTH-1:0]   wdata,
  output logic [DATA_WIDTH/8-1:0] wstrb,
  output logic                    wvalid,
  input  logic                    wready,
  input  logic [1:0]              bresp,
  input  logic                    bvalid,
  output logic                    bready,
  output logic [ADDR_WIDTH-1:0]   araddr,
  output logic                    arvalid,
  input  logic                    arready,
  input  logic [DATA_WIDTH-1:0]   rdata,
  input  logic [1:0]              rresp,
  input  logic                    rvalid,
  output logic                    rready
);

  localparam int OFF_W = $clog2(DATA_WIDTH / 8);
  localparam int TMO_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);

  lsu_state_e            state_q, state_d;
  lsu_err_e              err_q, err_d;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
  logic                  aw_done_q, aw_done_d, w_done_q, w_done_d;
  logic                  orphan_q, orphan_d;
  logic [TMO_W-1:0]      tmo_cnt_q, tmo_cnt_d;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [DATA_WIDTH-1:0] wdata_q;
  logic [1:0]            size_q;
  logic                  signed_q, we_q;

  logic                  accept, tmo_hit, waiting;
  logic [DATA_WIDTH-1:0] load_data;

  assign accept  = (state_q == IDLE) && req_valid;
  assign waiting = (state_q == RD_AR) || (state_q == RD_R) || (state_q == WR_AWW) || (state_q == WR_B);
  assign tmo_hit = (TIMEOUT_CYCLES != 0) && (tmo_cnt_q == TMO_LAST);

  ysyx_23060208_lsu_align #(.DATA_WIDTH(DATA_WIDTH)) u_align (
    .offset_i (addr_q[OFF_W-1:0]),
    .size_i   (size_q),
    .signed_i (signed_q),
    .wdata_i  (wdata_q),
    .rdata_i  (rdata),
    .wdata_o  (wdata),
    .wstrb_o  (wstrb),
    .rdata_o  (load_data)
  );

  always_comb begin
    state_d   = state_q;
    err_d     = err_q;
    rdata_d   = rdata_q;
    aw_done_d = aw_done_q;
    w_done_d  = w_done_q;
    orphan_d  = orphan_q;
    case (state_q)
      IDLE: if (req_valid) begin
        rdata_d   = '0;
        aw_done_d = 1'b0;
        w_done_d  = 1'b0;
        if (is_misaligned(req_size, req_addr[2:0], DATA_WIDTH == 64)) begin
          state_d = RESP;
          err_d   = ERR_MISALIGN;
        end else begin
          state_d = req_we ? WR_AWW : RD_AR;
          err_d   = ERR_OK;
        end
      end
      RD_AR: if (arready) state_d = RD_R;
             else if (tmo_hit) begin state_d = RESP; err_d = ERR_TIMEOUT; orphan_d = 1'b1; end
      RD_R: if (rvalid) begin
        state_d = RESP;
        if (rresp != AXI_OKAY) begin err_d = ERR_BUS; rdata_d = '0; end
        else rdata_d = load_data;
      end else if (tmo_hit) begin state_d = RESP; err_d = ERR_TIMEOUT; orphan_d = 1'b1; end
      WR_AWW: begin
        if (awvalid && awready) aw_done_d = 1'b1;
        if (wvalid && wready)   w_done_d  = 1'b1;
        if (aw_done_d && w_done_d) state_d = WR_B;
        else if (tmo_hit) begin state_d = RESP; err_d = ERR_TIMEOUT; orphan_d = 1'b1; end
      end
      WR_B: if (bvalid) begin
        state_d = RESP;
        err_d   = (bresp != AXI_OKAY) ? ERR_BUS : ERR_OK;
      end else if (tmo_hit) begin state_d = RESP; err_d = ERR_TIMEOUT; orphan_d = 1'b1; end
      RESP: if (resp_ready) state_d = orphan_q ? DRAIN : IDLE;
      // The late beat of a timed-out access is swallowed here, never reported.
      DRAIN: if (we_q ? bvalid : rvalid) begin state_d = IDLE; orphan_d = 1'b0; end
      default: state_d = IDLE;
    endcase
    tmo_cnt_d = (waiting && (state_d == state_q)) ? tmo_cnt_q + 1'b1 : '0;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= IDLE;
      err_q     <= ERR_OK;
      rdata_q   <= '0;
      aw_done_q <= 1'b0;
      w_done_q  <= 1'b0;
      orphan_q  <= 1'b0;
      tmo_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      err_q     <= err_d;
      rdata_q   <= rdata_d;
      aw_done_q <= aw_done_d;
      w_done_q  <= w_done_d;
      orphan_q  <= orphan_d;
      tmo_cnt_q <= tmo_cnt_d;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      addr_q   <= '0;
      wdata_q  <= '0;
      size_q   <= '0;
      signed_q <= 1'b0;
      we_q     <= 1'b0;
    end else if (accept) begin
      addr_q   <= req_addr;
      wdata_q  <= req_wdata;
      size_q   <= req_size;
      signed_q <= req_signed;
      we_q     <= req_we;
    end
  end

  assign req_ready  = (state_q == IDLE);
  assign resp_valid = (state_q == RESP);
  assign resp_rdata = rdata_q;
  assign resp_err   = err_q;
  assign awaddr     = addr_q;
  assign araddr     = addr_q;
  assign arvalid    = (state_q == RD_AR);
  assign awvalid    = (state_q == WR_AWW) && !aw_done_q;
  assign wvalid     = (state_q == WR_AWW) && !w_done_q;
  assign rready     = (state_q == RD_R) || (state_q == DRAIN);
  assign bready     = (state_q == WR_B) || (state_q == DRAIN);

endmodule

// File: tb/tb_ysyx_23060208_lsu.sv
// Bench for the LSU: a latency-configurable AXI4-Lite slave, a table of
// directed vectors, multi-cycle corner sequences and a random run vs. a model.
module tb_ysyx_23060208_lsu;
  import ysyx_23060208_pkg::*;

  logic clk = 1'b0, rst = 1'b0;
  always #5 clk = ~clk;

  logic req_valid = 0, req_ready, req_we = 0, req_signed = 0;
  logic [1:0] req_size = 0;
  logic [31:0] req_addr = 0, req_wdata = 0;
  logic resp_valid, resp_ready = 0;
  logic [31:0] resp_rdata;
  logic [1:0] resp_err;
  logic [31:0] awaddr, wdata, araddr, rdata = 0;
  logic [3:0] wstrb;
  logic awvalid, awready = 0, wvalid, wready = 0, bvalid = 0, bready;
  logic arvalid, arready = 0, rvalid = 0, rready;
  logic [1:0] bresp = 0, rresp = 0;

  ysyx_23060208_lsu #(.DATA_WIDTH(32), .ADDR_WIDTH(32), .TIMEOUT_CYCLES(8)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we), .req_size(req_size),
    .req_signed(req_signed), .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_rdata(resp_rdata), .resp_err(resp_err),
    .awaddr(awaddr), .awvalid(awvalid), .awready(awready),
    .wdata(wdata), .wstrb(wstrb), .wvalid(wvalid), .wready(wready),
    .bresp(bresp), .bvalid(bvalid), .bready(bready),
    .araddr(araddr), .arvalid(arvalid), .arready(arready),
    .rdata(rdata), .rresp(rresp), .rvalid(rvalid), .rready(rready)
  );

  int total = 0, bad = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // ---------------- AXI slave (decides at negedge, sees handshakes of the previous posedge)
  int cfg_ar_lat = 0, cfg_r_lat = 0, cfg_aw_lat = 0, cfg_w_lat = 0, cfg_b_lat = 0;
  logic [31:0] cfg_rdata = 0;
  logic [1:0] cfg_rresp = 0, cfg_bresp = 0;
  int ar_cnt, aw_cnt, w_cnt, r_cnt, b_cnt, bus_hs = 0;
  bit r_pend, b_pend, aw_got, w_got;
  logic p_arvalid, p_awvalid, p_wvalid, p_rready, p_bready;
  logic [31:0] p_araddr, p_awaddr, p_wdata, cap_araddr, cap_awaddr, cap_wdata;
  logic [3:0] p_wstrb, cap_wstrb;

  always @(negedge clk) begin
    if (!rst) begin
      ar_cnt = 0; aw_cnt = 0; w_cnt = 0; r_cnt = 0; b_cnt = 0;
      r_pend = 0; b_pend = 0; aw_got = 0; w_got = 0;
      arready = 0; awready = 0; wready = 0; rvalid = 0; bvalid = 0;
      p_arvalid = 0; p_awvalid = 0; p_wvalid = 0; p_rready = 0; p_bready = 0;
    end else begin
      if (p_arvalid && arready) begin r_pend = 1; r_cnt = 0; cap_araddr = p_araddr; bus_hs++; end
      if (p_rready && rvalid) r_pend = 0;
      if (p_awvalid && awready) begin aw_got = 1; cap_awaddr = p_awaddr; bus_hs++; end
      if (p_wvalid && wready) begin w_got = 1; cap_wdata = p_wdata; cap_wstrb = p_wstrb; bus_hs++; end
      if (p_bready && bvalid) b_pend = 0;
      if (aw_got && w_got) begin b_pend = 1; b_cnt = 0; aw_got = 0; w_got = 0; end
      ar_cnt = arvalid ? ar_cnt + 1 : 0;
      aw_cnt = awvalid ? aw_cnt + 1 : 0;
      w_cnt  = wvalid ? w_cnt + 1 : 0;
      arready = arvalid && (ar_cnt > cfg_ar_lat);
      awready = awvalid && (aw_cnt > cfg_aw_lat);
      wready  = wvalid && (w_cnt > cfg_w_lat);
      rvalid = r_pend && (rvalid || r_cnt >= cfg_r_lat);
      bvalid = b_pend && (bvalid || b_cnt >= cfg_b_lat);
      if (r_pend) r_cnt++;
      if (b_pend) b_cnt++;
      rdata = cfg_rdata; rresp = cfg_rresp; bresp = cfg_bresp;
      p_arvalid = arvalid; p_awvalid = awvalid; p_wvalid = wvalid; p_rready = rready; p_bready = bready;
      p_araddr = araddr; p_awaddr = awaddr; p_wdata = wdata; p_wstrb = wstrb;
    end
  end

  // ---------------- reference model: the access rules in plain arithmetic
  function automatic void model(input logic we, input logic [1:0] size, input logic sgn,
      input logic [31:0] addr, input logic [31:0] wd_in, input logic [31:0] rd_in,
      input logic [1:0] rr, input logic [1:0] br,
      output logic [1:0] err, output logic [31:0] rd, output logic [31:0] wd, output logic [3:0] st);
    int nbytes = 1 << size;
    int off = int'(addr % 4);
    longint unsigned v;
    err = 0; rd = 0; wd = 0; st = 0;
    if (size == 2'd3 || (addr % nbytes) != 0) begin err = 1; return; end
    for (int i = 0; i < nbytes; i++) begin
      st[off+i] = 1'b1;
      wd[8*(off+i) +: 8] = wd_in[8*i +: 8];
    end
    if (we) err = (br != 0) ? 2'd2 : 2'd0;
    else if (rr != 0) err = 2'd2;
    else begin
      v = (64'(rd_in) >> (8 * off)) % (64'd1 << (8 * nbytes));
      if (sgn && v >= (64'd1 << (8 * nbytes - 1))) v = v - (64'd1 << (8 * nbytes));
      rd = v[31:0];
    end
  endfunction

  function automatic logic [31:0] strb_mask(input logic [3:0] st);
    logic [31:0] m;
    for (int i = 0; i < 4; i++) m[8*i +: 8] = {8{st[i]}};
    return m;
  endfunction

  // ---------------- one transaction, started at a negedge while IDLE
  logic [1:0] t_err; logic [31:0] t_rd;
  int t_cyc, t_arv, t_wrb, t_rr; bit t_wv, t_got;

  task automatic run_txn(input logic we, input logic [1:0] size, input logic sgn,
                         input logic [31:0] addr, input logic [31:0] wd, input int hold);
    logic prev_bready = 0;
    req_valid = 1; req_we = we; req_size = size; req_signed = sgn; req_addr = addr; req_wdata = wd;
    t_cyc = 0; t_arv = 0; t_wrb = 0; t_rr = 0; t_wv = 0; t_got = 0;
    for (int i = 1; i <= 200; i++) begin
      @(negedge clk);
      req_valid = 0;
      t_cyc = i;
      if (arvalid) t_arv++;
      if (rready) t_rr++;
      if (awvalid || wvalid) t_wv = 1;
      if (bready && !prev_bready) t_wrb++;
      prev_bready = bready;
      if (resp_valid) begin t_got = 1; break; end
    end
    check("resp_arrives", t_got, 1);
    repeat (hold) @(negedge clk);
    t_err = resp_err; t_rd = resp_rdata;
    resp_ready = 1;
    @(negedge clk);
    resp_ready = 0;
  endtask

  typedef struct {
    logic we; logic [1:0] size; logic sgn;
    logic [31:0] addr, wd, rd; logic [1:0] rr, br;
    logic [1:0] e_err; logic [31:0] e_rd, e_wd; logic [3:0] e_st;
  } vec_t;

  function automatic vec_t mk(input logic we, input logic [1:0] size, input logic sgn,
      input logic [31:0] addr, input logic [31:0] wd, input logic [31:0] rd, input logic [1:0] rr,
      input logic [1:0] br, input logic [1:0] e_err, input logic [31:0] e_rd,
      input logic [31:0] e_wd, input logic [3:0] e_st);
    vec_t v;
    v.we = we; v.size = size; v.sgn = sgn; v.addr = addr; v.wd = wd; v.rd = rd; v.rr = rr; v.br = br;
    v.e_err = e_err; v.e_rd = e_rd; v.e_wd = e_wd; v.e_st = e_st;
    return v;
  endfunction

  vec_t vecs[14];

  initial begin
    #500000;
    $display("FAIL watchdog: got no_finish expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int hs0, busy;
    logic [1:0] m_err; logic [31:0] m_rd, m_wd; logic [3:0] m_st;
    logic we; logic [1:0] sz; logic sgn; logic [31:0] ad, wd;

    vecs[0]  = mk(0, 2, 0, 32'h8000_0004, 0, 32'hDEAD_BEEF, 0, 0, 0, 32'hDEAD_BEEF, 0, 0);
    vecs[1]  = mk(0, 0, 1, 32'h8000_0003, 0, 32'h80FF_FFFF, 0, 0, 0, 32'hFFFF_FF80, 0, 0);
    vecs[2]  = mk(0, 0, 0, 32'h8000_0003, 0, 32'h80FF_FFFF, 0, 0, 0, 32'h0000_0080, 0, 0);
    vecs[3]  = mk(0, 1, 1, 32'h8000_0002, 0, 32'h8001_7FFF, 0, 0, 0, 32'hFFFF_8001, 0, 0);
    vecs[4]  = mk(0, 1, 0, 32'h8000_0000, 0, 32'h1234_ABCD, 0, 0, 0, 32'h0000_ABCD, 0, 0);
    vecs[5]  = mk(0, 0, 1, 32'h8000_0001, 0, 32'h0000_7F00, 0, 0, 0, 32'h0000_007F, 0, 0);
    vecs[6]  = mk(0, 2, 0, 32'h8000_0008, 0, 32'h0000_0055, 2, 0, 2, 0, 0, 0);
    vecs[7]  = mk(0, 1, 1, 32'h8000_0003, 0, 32'h1111_1111, 0, 0, 1, 0, 0, 0);
    vecs[8]  = mk(0, 3, 0, 32'h8000_0000, 0, 32'h1111_1111, 0, 0, 1, 0, 0, 0);
    vecs[9]  = mk(1, 1, 0, 32'h8000_0002, 32'h0000_1234, 0, 0, 0, 0, 0, 32'h1234_0000, 4'b1100);
    vecs[10] = mk(1, 0, 0, 32'h8000_0001, 32'h0000_00AB, 0, 0, 0, 0, 0, 32'h0000_AB00, 4'b0010);
    vecs[11] = mk(1, 2, 0, 32'h8000_0000, 32'hCAFE_F00D, 0, 0, 0, 0, 0, 32'hCAFE_F00D, 4'b1111);
    vecs[12] = mk(1, 2, 0, 32'h8000_0001, 32'h1234_5678, 0, 0, 0, 1, 0, 0, 0);
    vecs[13] = mk(1, 0, 0, 32'h8000_0003, 32'h0000_005A, 0, 0, 3, 2, 0, 32'h5A00_0000, 4'b1000);

    // reset state
    repeat (2) @(negedge clk);
    check("rst_req_ready", req_ready, 1);
    check("rst_valids", {resp_valid, arvalid, awvalid, wvalid, rready, bready}, 0);
    check("rst_resp", {resp_err, resp_rdata}, 0);
    rst = 1;
    @(negedge clk);

    // word load, arready delayed 3 cycles, response held 3 cycles before taken
    cfg_ar_lat = 3;
    run_txn(0, 2, 0, 32'h8000_0004, 0, 0);
    cfg_rdata = 32'hDEAD_BEEF;
    cfg_ar_lat = 3;
    run_txn(0, 2, 0, 32'h8000_0004, 0, 3);
    check("wload_rdata", t_rd, 32'hDEAD_BEEF);
    check("wload_err", t_err, 0);
    check("wload_arvalid_cycles", t_arv, 4);
    check("wload_araddr", cap_araddr, 32'h8000_0004);
    cfg_ar_lat = 0;

    // half store, W accepted one cycle before AW
    cfg_aw_lat = 1; cfg_w_lat = 0;
    run_txn(1, 1, 0, 32'h8000_0002, 32'h0000_1234, 0);
    check("hstore_wdata", cap_wdata, 32'h1234_0000);
    check("hstore_wstrb", cap_wstrb, 4'b1100);
    check("hstore_awaddr", cap_awaddr, 32'h8000_0002);
    check("hstore_wrb_entries", t_wrb, 1);
    check("hstore_err", t_err, 0);
    cfg_aw_lat = 0;

    // misaligned word store
    hs0 = bus_hs;
    run_txn(1, 2, 0, 32'h8000_0001, 32'hFFFF_FFFF, 0);
    check("mis_err", t_err, 1);
    check("mis_latency_le2", t_cyc <= 2, 1);
    check("mis_no_aw_w", t_wv, 0);
    check("mis_no_handshake", bus_hs - hs0, 0);

    // table-driven vectors
    foreach (vecs[i]) begin
      cfg_rdata = vecs[i].rd; cfg_rresp = vecs[i].rr; cfg_bresp = vecs[i].br;
      hs0 = bus_hs;
      run_txn(vecs[i].we, vecs[i].size, vecs[i].sgn, vecs[i].addr, vecs[i].wd, 0);
      check($sformatf("vec%0d_err", i), t_err, vecs[i].e_err);
      check($sformatf("vec%0d_rdata", i), t_rd, vecs[i].e_rd);
      if (vecs[i].e_err == 2'd1) begin
        check($sformatf("vec%0d_no_bus", i), {t_wv, t_arv != 0, bus_hs != hs0}, 0);
      end else if (vecs[i].we) begin
        check($sformatf("vec%0d_wdata", i), cap_wdata & strb_mask(vecs[i].e_st), vecs[i].e_wd);
        check($sformatf("vec%0d_wstrb", i), cap_wstrb, vecs[i].e_st);
      end
    end
    cfg_rresp = 0; cfg_bresp = 0;

    // timeout: R beat withheld, 8 wait cycles, then DRAIN until the late beat
    cfg_r_lat = 1000;
    run_txn(0, 2, 0, 32'h8000_0010, 0, 0);
    check("tmo_err", t_err, 3);
    check("tmo_wait_cycles", t_rr, 8);
    check("drain_req_ready", req_ready, 0);
    check("drain_rready", rready, 1);
    busy = 0;
    repeat (3) begin
      @(negedge clk);
      if (req_ready || resp_valid || arvalid) busy++;
    end
    check("drain_holds", busy, 0);
    cfg_r_lat = 0;
    busy = 0;
    for (int i = 0; i < 20 && !req_ready; i++) begin
      @(negedge clk);
      if (resp_valid) busy++;
    end
    check("drain_exit", req_ready, 1);
    check("drain_no_resp", busy, 0);

    // reset in WR_B: no response afterwards, then a bus error store
    cfg_b_lat = 1000;
    req_valid = 1; req_we = 1; req_size = 2; req_addr = 32'h8000_0020; req_wdata = 32'h0BAD_F00D;
    @(negedge clk);
    req_valid = 0;
    for (int i = 0; i < 20 && !bready; i++) @(negedge clk);
    check("rstmid_in_wrb", bready, 1);
    rst = 0;
    #1;
    check("rstmid_valids", {resp_valid, arvalid, awvalid, wvalid, rready, bready}, 0);
    check("rstmid_req_ready", req_ready, 1);
    @(negedge clk);
    @(negedge clk);
    rst = 1; cfg_b_lat = 0;
    busy = 0;
    repeat (10) begin
      @(negedge clk);
      if (resp_valid) busy++;
    end
    check("rstmid_no_resp", busy, 0);
    cfg_bresp = AXI_SLVERR;
    run_txn(1, 2, 0, 32'h8000_0024, 32'h1111_2222, 0);
    check("bus_err_store", t_err, 2);
    cfg_bresp = 0;

    // randomized traffic against the model
    for (int n = 0; n < 60; n++) begin
      we = 1'($urandom_range(0, 1));
      sz = ($urandom_range(0, 9) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
      sgn = 1'($urandom_range(0, 1));
      ad = 32'h8000_0000 | ($urandom & 32'h0000_0FFF);
      if ($urandom_range(0, 3) != 0) ad = ad & ~((32'd1 << sz) - 32'd1);
      wd = $urandom;
      cfg_rdata = $urandom;
      cfg_rresp = ($urandom_range(0, 7) == 0) ? 2'($urandom_range(1, 3)) : 2'd0;
      cfg_bresp = ($urandom_range(0, 7) == 0) ? 2'($urandom_range(1, 3)) : 2'd0;
      cfg_ar_lat = $urandom_range(0, 4); cfg_r_lat = $urandom_range(0, 4);
      cfg_aw_lat = $urandom_range(0, 4); cfg_w_lat = $urandom_range(0, 4);
      cfg_b_lat = $urandom_range(0, 4);
      model(we, sz, sgn, ad, wd, cfg_rdata, cfg_rresp, cfg_bresp, m_err, m_rd, m_wd, m_st);
      hs0 = bus_hs;
      run_txn(we, sz, sgn, ad, wd, 0);
      check($sformatf("rnd%0d_err", n), t_err, m_err);
      check($sformatf("rnd%0d_rdata", n), t_rd, m_rd);
      if (m_err == 2'd1) check($sformatf("rnd%0d_no_bus", n), bus_hs - hs0, 0);
      else if (we) begin
        check($sformatf("rnd%0d_wdata", n), cap_wdata & strb_mask(m_st), m_wd);
        check($sformatf("rnd%0d_wstrb", n), cap_wstrb, m_st);
        check($sformatf("rnd%0d_awaddr", n), cap_awaddr, ad);
      end else check($sformatf("rnd%0d_araddr", n), cap_araddr, ad);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/ysyx_23060208_lsu.md
YSYX_23060208_LSU -- requirements
Module: ysyx_23060208_lsu

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, data bus width; only 32 or 64 are legal.
REQ-002 SHALL have parameter ADDR_WIDTH, default 32, address width.
REQ-003 SHALL have parameter TIMEOUT_CYCLES, default 1024, bus-wait limit in cycles; 0 disables the timeout.
REQ-004 SHALL have port clk, input, 1 bit: the single clock, rising edge.
REQ-005 SHALL have port rst, input, 1 bit: asynchronous, active-low reset.
REQ-006 SHALL have the request ports req_valid/req_ready (in/out, 1 bit each), req_we (in, 1), req_size (in, 2: 0=B, 1=H, 2=W, 3=D), req_signed (in, 1), req_addr (in, ADDR_WIDTH) and req_wdata (in, DATA_WIDTH, right-aligned).
REQ-007 SHALL have the response ports resp_valid (out, 1), resp_ready (in, 1), resp_rdata (out, DATA_WIDTH, extended) and resp_err (out, 2: 0=OK, 1=MISALIGN, 2=BUS, 3=TIMEOUT).
REQ-008 SHALL have AXI4-Lite master channels AW (awaddr, awvalid, awready), W (wdata, wstrb[DATA_WIDTH/8], wvalid, wready), B (bresp[2], bvalid, bready), AR (araddr, arvalid, arready) and R (rdata, rresp[2], rvalid, rready).

Function
REQ-009 SHALL implement the FSM states IDLE, RD_AR, RD_R, WR_AWW, WR_B, RESP and DRAIN.
REQ-010 SHALL drive req_ready=1 only in IDLE; a request is accepted on req_valid&&req_ready and latched into registers.
REQ-011 SHALL detect misalignment as a nonzero addr[log2(bytes)-1:0]; size 3 at DATA_WIDTH=32 is also MISALIGN.
REQ-012 SHALL move a misaligned request from IDLE to RESP with err=1, issuing no bus transaction.
REQ-013 SHALL move an aligned load from IDLE to RD_AR; arvalid is registered and asserted the first cycle after acceptance, then held until arready.
REQ-014 SHALL move from RD_AR to RD_R on arready, with rready=1 in RD_R; on rvalid it captures the data and moves to RESP.
REQ-015 SHALL move an aligned store from IDLE to WR_AWW, asserting awvalid and wvalid together the next cycle.
REQ-016 SHALL track AW and W done flags independently in WR_AWW; each valid drops after its own handshake, and the state moves to WR_B only when both are done, in either order or the same cycle.
REQ-017 SHALL drive bready=1 in WR_B; bvalid moves the FSM to RESP.
REQ-018 SHALL drive awaddr/araddr with the full request address; the lane offset is addr mod (DATA_WIDTH/8).
REQ-019 SHALL shift wdata left by 8*offset; wstrb has (1<<size) ones shifted left by offset.
REQ-020 SHALL shift the load data right by 8*offset, truncate it to the access size, and sign-extend when req_signed, else zero-extend.
REQ-021 SHALL report a nonzero rresp or bresp as err=2; resp_rdata is then 0.
REQ-022 SHALL hold resp_valid=1 in RESP until resp_ready, then return to IDLE; back-to-back requests have one IDLE cycle between them.
REQ-023 SHALL reset the timeout counter on every state entry and count in RD_AR, RD_R, WR_AWW and WR_B; reaching TIMEOUT_CYCLES moves to RESP with err=3 and sets an orphan flag.
REQ-024 SHALL handle an outstanding orphan after a timeout as follows:
  - once the timeout response is taken, go to DRAIN, not IDLE;
  - hold rready/bready=1 and all valids=0 in DRAIN;
  - the pending AR/AW/W handshakes may still complete there;
  - the late R or B beat is discarded, then the FSM returns to IDLE.
REQ-025 SHALL keep resp_rdata, resp_err and all address and data outputs stable while their valid is high.

Reset
REQ-026 SHALL force on rst=0 (async): state=IDLE, req_ready=1, and 0 for resp_valid, all AXI valids, rready, bready, resp_err, resp_rdata, counters and flags.
REQ-027 SHALL drop any in-flight transaction silently on reset, with no response produced.

Structure
REQ-028 SHALL place the FSM state enum, resp_err codes, req_size codes and AXI resp codes in shared package ysyx_23060208_pkg.
REQ-029 SHALL put the lane shift, strobe generation and sign/zero extension in a combinational sub-module, ysyx_23060208_lsu_align.

Verification
REQ-030 SHALL verify a word load: addr 0x8000_0004, rdata 0xDEAD_BEEF, arready delayed 3 cycles -> resp_rdata 0xDEADBEEF, err 0, arvalid high for 4 cycles.
REQ-031 SHALL verify a signed byte load: addr 0x8000_0003, rdata 0x80FF_FFFF -> resp_rdata 0xFFFFFF80; unsigned -> 0x00000080.
REQ-032 SHALL verify a half store: addr 0x8000_0002, wdata 0x1234 -> wdata 0x1234_0000, wstrb 4'b1100; with wready one cycle before awready, WR_B is entered once.
REQ-033 SHALL verify a misaligned word store at 0x8000_0001 -> err 1 within 2 cycles, awvalid/wvalid never asserted.
REQ-034 SHALL verify a timeout: TIMEOUT_CYCLES=8, load with rvalid withheld -> err 3 after 8 wait cycles, DRAIN entered, req_ready=0 until a late rvalid beat is consumed.
REQ-035 SHALL verify reset mid-operation: rst=0 during WR_B -> all valids 0 immediately, no response after release; then bresp=2 on a fresh store -> err 2.
